// File: rtl/keymgr_sideload_pkg.sv
// Shared types and sizes for the sideload key loader.
// Contents: key geometry localparams, the packed hw_key_req_t bus
// {valid, key[1], key[0]} and the loader state enum.
package keymgr_sideload_pkg;
  localparam int KeyWidth  = 256;
  localparam int NumShares = 2;
  localparam int WordWidth = 32;
  localparam int NumWords  = NumShares * KeyWidth / WordWidth;
  localparam int CntWidth  = $clog2(NumWords);

  localparam logic [CntWidth-1:0] LastCnt = CntWidth'(NumWords - 1);

  typedef struct packed {
    logic                                valid;
    logic [NumShares-1:0][KeyWidth-1:0]  key;
  } hw_key_req_t;

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StActive,
    StWipe
  } sideload_st_e;
endpackage

// File: rtl/keymgr_sideload_fsm.sv
// Control FSM for the sideload key loader.
// Owns the state register, the 4-bit slot counter and start/clr arbitration
// (clr always wins). Produces the word handshake ready, busy, the done and
// err pulses, and the write controls the key register file consumes.
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   start, clr          new-load and wipe requests
//   word_valid          upstream word offered
//   state, cnt          current state and slot pointer
//   ready, busy         word accepted / LOAD-or-WIPE indication
//   done, err           registered one-cycle pulses
//   key_clr             zero every slot this cycle
//   word_we, ent_we     write word / entropy into slot cnt
module keymgr_sideload_fsm
  import keymgr_sideload_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                clr,
  input  logic                word_valid,
  output sideload_st_e        state,
  output logic [CntWidth-1:0] cnt,
  output logic                ready,
  output logic                busy,
  output logic                done,
  output logic                err,
  output logic                key_clr,
  output logic                word_we,
  output logic                ent_we
);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= StIdle;
      cnt   <= '0;
      done  <= 1'b0;
      err   <= 1'b0;
    end else begin
      done <= 1'b0;
      // Words offered while not loading are dropped and flagged.
      err  <= word_valid && (state != StLoad);
      if (clr) begin
        state <= StWipe;
        cnt   <= '0;
      end else begin
        case (state)
          StIdle: begin
            if (start) begin
              state <= StLoad;
              cnt   <= '0;
            end
          end
          StLoad: begin
            // A restart beats the final handshake, so no done in that case.
            if (start) begin
              cnt <= '0;
            end else if (word_valid) begin
              cnt <= cnt + 1'b1;
              if (cnt == LastCnt) begin
                state <= StActive;
                done  <= 1'b1;
              end
            end
          end
          StActive: begin
            if (start) begin
              state <= StLoad;
              cnt   <= '0;
            end
          end
          StWipe: begin
            cnt <= cnt + 1'b1;
            if (cnt == LastCnt) state <= StIdle;
          end
          default: state <= StIdle;
        endcase
      end
    end
  end

  assign ready   = (state == StLoad);
  assign busy    = (state == StLoad) || (state == StWipe);
  // A wipe in progress ignores start, so it must not zero the slots either.
  assign key_clr = start && !clr && (state != StWipe);
  assign word_we = ready && word_valid && !start && !clr;
  assign ent_we  = (state == StWipe) && !clr;

endmodule

// File: rtl/keymgr_sideload_loader.sv
// Sideload key producer: assembles a two-share key from a 32-bit word
// stream into hw_key_req_t, and wipes it with entropy on request.
// Ports:
//   clk_i, rst_ni       clock, synchronous active-low reset
//   start_i, clr_i      begin new load / wipe key (pulses)
//   word_valid_i/ready  word handshake; word n lands in bits [n*32 +: 32]
//   word_i, entropy_i   load data / wipe data
//   key_o               {valid, key[1], key[0]}
//   busy_o, done_o, err_o  status
module keymgr_sideload_loader
  import keymgr_sideload_pkg::*;
(
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   start_i,
  input  logic                   clr_i,
  input  logic                   word_valid_i,
  output logic                   word_ready_o,
  input  logic [WordWidth-1:0]   word_i,
  input  logic [WordWidth-1:0]   entropy_i,
  output logic [512:0]           key_o,
  output logic                   busy_o,
  output logic                   done_o,
  output logic                   err_o
);

  sideload_st_e                      state;
  logic [CntWidth-1:0]               cnt;
  logic                              key_clr, word_we, ent_we;
  logic [NumWords-1:0][WordWidth-1:0] slots;
  hw_key_req_t                       req;

  keymgr_sideload_fsm u_fsm (
    .clk        (clk_i),
    .rst_n      (rst_ni),
    .start      (start_i),
    .clr        (clr_i),
    .word_valid (word_valid_i),
    .state      (state),
    .cnt        (cnt),
    .ready      (word_ready_o),
    .busy       (busy_o),
    .done       (done_o),
    .err        (err_o),
    .key_clr    (key_clr),
    .word_we    (word_we),
    .ent_we     (ent_we)
  );

  // Flat slot n maps to share n/8, bits (n%8)*32, i.e. key bits [n*32 +: 32].
  always_ff @(posedge clk_i) begin
    if (!rst_ni || key_clr) begin
      slots <= '0;
    end else if (word_we) begin
      slots[cnt] <= word_i;
    end else if (ent_we) begin
      slots[cnt] <= entropy_i;
    end
  end

  assign req.valid = (state == StActive);
  assign req.key   = slots;
  assign key_o     = req;

endmodule

// File: tb/tb_keymgr_sideload_loader.sv
module tb_keymgr_sideload_loader;
  logic         clk = 1'b0;
  logic         rst_n, start, clr, wv, ready, busy, done, err;
  logic [31:0]  word, ent;
  logic [512:0] key_o;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  keymgr_sideload_loader dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .start_i      (start),
    .clr_i        (clr),
    .word_valid_i (wv),
    .word_ready_o (ready),
    .word_i       (word),
    .entropy_i    (ent),
    .key_o        (key_o),
    .busy_o       (busy),
    .done_o       (done),
    .err_o        (err)
  );

  // Reference model: mode 0 idle, 1 loading, 2 holding key, 3 wiping.
  int          m_mode;
  int          m_pos;
  logic [31:0] m_key [16];
  bit          m_done, m_err;

  function automatic void model_reset();
    m_mode = 0; m_pos = 0; m_done = 0; m_err = 0;
    for (int i = 0; i < 16; i++) m_key[i] = '0;
  endfunction

  function automatic void model_step(bit r, bit s, bit c, bit v,
                                     logic [31:0] w, logic [31:0] e);
    if (!r) begin
      model_reset();
      return;
    end
    m_err  = v && (m_mode != 1);
    m_done = 0;
    if (c) begin
      m_mode = 3; m_pos = 0;
    end else if (m_mode == 3) begin
      m_key[m_pos] = e;
      m_pos++;
      if (m_pos == 16) begin m_mode = 0; m_pos = 0; end
    end else if (s) begin
      m_mode = 1; m_pos = 0;
      for (int i = 0; i < 16; i++) m_key[i] = '0;
    end else if (m_mode == 1 && v) begin
      m_key[m_pos] = w;
      m_pos++;
      if (m_pos == 16) begin m_mode = 2; m_pos = 0; m_done = 1; end
    end
  endfunction

  function automatic logic [512:0] model_key();
    logic [512:0] k;
    k = '0;
    for (int i = 0; i < 16; i++) k[i*32 +: 32] = m_key[i];
    k[512] = (m_mode == 2);
    return k;
  endfunction

  task automatic chk(input string name, input logic [512:0] act, input logic [512:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // One clock: drive inputs, take the edge, sample 1 ns later, compare to model.
  task automatic cycle(input bit r, input bit s, input bit c, input bit v,
                       input logic [31:0] w, input logic [31:0] e);
    rst_n = r; start = s; clr = c; wv = v; word = w; ent = e;
    @(posedge clk);
    #1;
    model_step(r, s, c, v, w, e);
    chk("model_key", key_o, model_key());
    chk("model_flags", {509'b0, ready, busy, done, err},
        {509'b0, (m_mode == 1), (m_mode == 1 || m_mode == 3), m_done, m_err});
  endtask

  task automatic idle();
    cycle(1, 0, 0, 0, 32'h0, $urandom);
  endtask

  typedef struct {
    bit          s, c, v;
    logic [31:0] w;
    logic [3:0]  exp; // {ready, busy, done, err}
  } vec_t;

  vec_t         vecs[$];
  logic [511:0] seq_key, snap;
  int           n;

  initial begin
    model_reset();
    rst_n = 0; start = 0; clr = 0; wv = 0; word = 0; ent = 0;

    // Reset state
    cycle(0, 0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 0);
    chk("reset_key", key_o, '0);
    chk("reset_flags", {509'b0, ready, busy, done, err}, '0);

    // Test 1: table of a back-to-back load then a stray word in ACTIVE
    vecs.push_back('{s:1, c:0, v:0, w:0, exp:4'b1100});
    for (int i = 0; i < 16; i++)
      vecs.push_back('{s:0, c:0, v:1, w:i, exp:(i == 15) ? 4'b0010 : 4'b1100});
    vecs.push_back('{s:0, c:0, v:1, w:32'hDEAD, exp:4'b0001});
    for (int i = 0; i < vecs.size(); i++) begin
      cycle(1, vecs[i].s, vecs[i].c, vecs[i].v, vecs[i].w, $urandom);
      chk($sformatf("vec%0d", i), {509'b0, ready, busy, done, err}, {509'b0, vecs[i].exp});
    end
    chk("t1_valid", {512'b0, key_o[512]}, 513'd1);
    chk("t1_w0", {481'b0, key_o[31:0]}, 513'h0);
    chk("t1_w8", {481'b0, key_o[287:256]}, 513'h8);
    chk("t1_w15", {481'b0, key_o[511:480]}, 513'hF);
    for (int i = 0; i < 16; i++) seq_key[i*32 +: 32] = i;

    // Test 2: start from ACTIVE, then valid toggling 1/0 over 31 cycles
    cycle(1, 1, 0, 0, 0, $urandom);
    chk("t2_restart_key", key_o, '0);
    n = 0;
    for (int i = 0; i < 31; i++) begin
      cycle(1, 0, 0, (i % 2) == 0, i / 2, $urandom);
      if (busy) n++;
    end
    chk("t2_busy_cycles", n, 30);
    chk("t2_done", {512'b0, done}, 513'd1);
    chk("t2_key", key_o, {1'b1, seq_key});

    // Test 3: wipe an active key with a fixed entropy pattern
    cycle(1, 0, 1, 0, 0, 32'hA5A5A5A5);
    chk("t3_valid_drop", {512'b0, key_o[512]}, '0);
    n = busy ? 1 : 0;
    repeat (18) begin
      cycle(1, 0, 0, 0, 0, 32'hA5A5A5A5);
      if (busy) n++;
    end
    chk("t3_busy_cycles", n, 16);
    chk("t3_key", key_o, {1'b0, {16{32'hA5A5A5A5}}});

    // Test 4: stray word in IDLE, then start+clr together
    snap = key_o[511:0];
    cycle(1, 0, 0, 1, 32'h12345678, $urandom);
    chk("t4_err", {512'b0, err}, 513'd1);
    chk("t4_ready", {512'b0, ready}, '0);
    chk("t4_key_held", key_o, {1'b0, snap});
    cycle(1, 1, 1, 0, 0, $urandom);
    chk("t4_clr_wins", {511'b0, busy, ready}, 513'b10);
    repeat (16) idle();
    chk("t4_back_idle", {512'b0, busy}, '0);

    // Test 5: restart mid-load, full load, then start on the final handshake
    cycle(1, 1, 0, 0, 0, $urandom);
    repeat (8) cycle(1, 0, 0, 1, $urandom, $urandom);
    cycle(1, 1, 0, 0, 0, $urandom);
    chk("t5_restart_zero", key_o, '0);
    for (int i = 0; i < 16; i++) cycle(1, 0, 0, 1, $urandom, $urandom);
    chk("t5_done", {512'b0, done}, 513'd1);
    cycle(1, 1, 0, 0, 0, $urandom);
    repeat (15) cycle(1, 0, 0, 1, $urandom, $urandom);
    cycle(1, 1, 0, 1, $urandom, $urandom);
    chk("t5_no_done", {511'b0, done, key_o[512]}, '0);
    chk("t5_still_load", {512'b0, ready}, 513'd1);

    // Test 6: reset during WIPE at cnt=5
    cycle(1, 0, 1, 0, 0, 32'hFFFF0001);
    repeat (5) cycle(1, 0, 0, 0, 0, 32'hFFFF0001);
    chk("t6_partial", {481'b0, key_o[159:128]}, 513'hFFFF0001);
    cycle(0, 0, 0, 0, 0, 32'hFFFF0001);
    chk("t6_reset_key", key_o, '0);
    chk("t6_reset_busy", {512'b0, busy}, '0);

    // Random traffic against the model
    for (int i = 0; i < 3000; i++)
      cycle($urandom_range(199) != 0, $urandom_range(19) == 0, $urandom_range(29) == 0,
            $urandom_range(9) < 6, $urandom, $urandom);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Safety net in case the clock ever stalls the initial block.
  initial begin
    #2000000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1);
  end
endmodule
